// File: rtl/azadi_boot_uart_tx.sv
// azadi_boot_uart_tx: 8N1 UART transmitter fed from a small byte FIFO.
// The bit period comes from clk_per_bits and is latched at each frame start.
// Optional feature: define UART_TX_PARITY_EN to append an even-parity bit
// after the data bits, which makes each frame 11 bit periods long.

module azadi_boot_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [15:0]                   clk_per_bits,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_o,
    output logic                          tx_en_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    // FIFO storage and pointers (one extra MSB separates full from empty)
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        start_frame;
    logic        can_start;

    // Transmit engine state
    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] period_q, period_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    // Registered outputs
    logic        tx_o_q, tx_o_d;
    logic        tx_en_q, tx_en_d;
    logic        busy_q, busy_d;

    assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Readiness ignores a same-cycle pop, so a full FIFO never takes a byte.
    assign tx_ready_o   = !fifo_full && !wb_rst_i;
    assign push         = tx_valid_i && tx_ready_o;
    assign fifo_level_o = wr_ptr_q - rd_ptr_q;
    // A zero period parks the engine in IDLE while the FIFO keeps filling.
    assign can_start    = !fifo_empty && (clk_per_bits != 16'd0);

    assign tx_o    = tx_o_q;
    assign tx_en_o = tx_en_q;
    assign busy_o  = busy_q;

    // Write the incoming byte into the slot addressed by the write pointer
    // NOTE: the storage array has no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_data_i;
        end
    end

    // Next-state logic for the FIFO pointers, bit timer, shifter and line outputs
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        timer_d     = timer_q;
        period_d    = period_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        start_frame = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (can_start) begin
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (timer_q == 16'd0) begin
                    state_d   = S_DATA;
                    timer_d   = period_q - 16'd1;
                    bit_cnt_d = 3'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_DATA: begin
                if (timer_q == 16'd0) begin
                    timer_d = period_q - 16'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (timer_q == 16'd0) begin
                    state_d = S_STOP;
                    timer_d = period_q - 16'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (timer_q == 16'd0) begin
                    if (can_start) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Frame start: pop the head byte and latch the period for the whole frame
        if (start_frame) begin
            state_d  = S_START;
            shift_d  = mem_q[rd_ptr_q[AW-1:0]];
            period_d = clk_per_bits;
            timer_d  = clk_per_bits - 16'd1;
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q[AW-1:0]];
`endif
        end

        pop      = start_frame;
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        // The line follows the current state one cycle later
        unique case (state_q)
            S_START:  tx_o_d = 1'b0;
            S_DATA:   tx_o_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_o_d = parity_q;
`endif
            default:  tx_o_d = 1'b1;
        endcase
        tx_en_d = (state_q != S_IDLE);
        busy_d  = (state_q != S_IDLE) || !fifo_empty;
    end

    // State register; reset aborts any frame and flushes the FIFO
    // NOTE: clocked state uses non-blocking assignments so all flops update together.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            timer_q   <= 16'd0;
            period_q  <= 16'd0;
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
            tx_o_q    <= 1'b1;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            timer_q   <= timer_d;
            period_q  <= period_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
            tx_o_q    <= tx_o_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: doc/azadi_boot_uart_tx.md
# azadi_boot_uart_tx

Serial 8N1 UART transmitter that streams bytes from a small FIFO onto a single pad line. It is the transmit-side counterpart of the SoC's program-load/peripheral UART receiver. The bit period comes from the same logic-analyzer-driven `clk_per_bits` word the receiver uses, so both ends of a link stay matched. It sits in the Caravel user wrapper, is clocked by the Wishbone clock, and drives an `io_out`/`io_oeb` pad pair.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: byte FIFO entries; power of two, 2..64.

Ports:
- `wb_clk_i`  input  1  system clock
- `wb_rst_i`  input  1  reset; synchronous, active-high
- `clk_per_bits`  input  16  clock cycles per serial bit
- `tx_data_i`  input  8  byte to send
- `tx_valid_i`  input  1  `tx_data_i` is valid
- `tx_ready_o`  output  1  FIFO can accept a byte
- `tx_o`  output  1  serial line; idles high
- `tx_en_o`  output  1  pad output enable; high while a frame is on the line
- `busy_o`  output  1  frame in progress or FIFO non-empty
- `fifo_level_o`  output  $clog2(FIFO_DEPTH)+1  bytes currently queued

## Operation
- **Push.** A byte is written on a rising edge where `tx_valid_i && tx_ready_o`.
  - `tx_ready_o` = !full && !`wb_rst_i`.
  - A push into a full FIFO cannot happen. A pop in the same cycle does not make room for a push.
- **State machine** states: IDLE, START, DATA, STOP (plus PARITY when `UART_TX_PARITY_EN` is defined).
  - IDLE: if the FIFO is non-empty and `clk_per_bits` != 0, pop the head byte into a shift register, latch `clk_per_bits` into the period register, and go to START.
  - START: drive 0 for one period, then go to DATA.
  - DATA: shift out 8 bits LSB first, one period each. A 3-bit counter selects the bit. After bit 7, go to PARITY or STOP.
  - STOP: drive 1 for one period. Then go to START if the FIFO is non-empty and `clk_per_bits` != 0 (popping as IDLE does); otherwise go to IDLE.
- **Bit timer.** A 16-bit down-counter loaded with the latched period minus 1 and decremented each cycle. A bit ends when the counter reads 0.
  - `clk_per_bits` changes take effect only at the next frame start.
- **`clk_per_bits` = 0:** the block stays in IDLE. The FIFO still accepts bytes up to full. `tx_o` stays 1.
- **`clk_per_bits` = 1:** legal; each bit lasts one cycle.
- **`tx_en_o`** is 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- **FIFO** uses wrap-around read/write pointers with one extra MSB to tell full from empty.
  - `fifo_level_o` = wr_ptr − rd_ptr, modulo 2^(ptr width).
  - Simultaneous push and pop leaves the level unchanged.

## Timing
- **Reset values** (registered, apply the edge after `wb_rst_i` is sampled high): `tx_o`=1, `tx_en_o`=0, `busy_o`=0, `fifo_level_o`=0, `tx_ready_o`=0 while reset is asserted. State returns to IDLE.
- **Reset mid-frame:** the frame is aborted and the FIFO flushed. `tx_o` returns to 1 on the next edge; no partial stop bit is sent.
- **Latency:** a byte pushed at edge N with the FIFO empty and state IDLE is popped at edge N+1. `tx_o`=0 (start bit) from edge N+2.
- **Frame length:** 10·P cycles, or 11·P with parity, where P = latched `clk_per_bits`.
- **Back-to-back bytes:** the next start bit begins immediately after the last stop-bit cycle, with zero idle cycles. `tx_en_o` stays high across the frames.
- **Outputs:** all are registered except `tx_ready_o` and `fifo_level_o`, which are combinational from registered pointers.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the PARITY state is inserted after DATA and drives even parity (XOR of the 8 data bits) for one period. Frame is 11·P cycles.
- **Not defined:** no PARITY state; frame is 10·P cycles. The receiver must be built with the matching setting.

## Test plan
- **Single byte:** reset, `clk_per_bits`=4, push 0xA5 → `tx_o` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, starting 2 cycles after the push. `tx_en_o` high for exactly 40 cycles.
- **Back-to-back:** `clk_per_bits`=1, push 0x00 then 0xFF on consecutive cycles → 20 contiguous line cycles: 0, eight 0s, 1, 0, eight 1s, 1. No idle gap; `busy_o` falls the cycle after the final stop bit.
- **FIFO full:** `FIFO_DEPTH`=8, `clk_per_bits`=0, push 9 bytes → `tx_ready_o`=0 after the 8th push, `fifo_level_o`=8, 9th byte dropped. Then set `clk_per_bits`=2 → all 8 bytes sent in order.
- **Reset mid-frame:** `clk_per_bits`=16, push 0x3C, assert `wb_rst_i` for 1 cycle during DATA bit 3 → `tx_o`=1 and `tx_en_o`=0 next edge, `fifo_level_o`=0, no further transitions.
- **Period change mid-frame:** `clk_per_bits`=8, push 0x55 and 0xAA, change to 3 during the first frame → first frame 80 cycles, second frame 30 cycles.
- **Parity (`UART_TX_PARITY_EN` defined):** push 0x07 → parity bit 1. Push 0x03 → parity bit 0. Each frame is 11 periods.
